// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight writers, raises load-use stall, registers forwarding selects.
// Optional performance counters are enabled by defining HAZARD_SCOREBOARD_PERF_EN.
module hazard_scoreboard #(
    parameter int NSRC       = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_AVAIL = 3,
    parameter int SW         = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NSRC-1:0][4:0]      id_rs,
    input  logic [NSRC-1:0]           id_rs_used,
    input  logic [4:0]                id_rd,
    input  logic                      id_we,
    input  logic                      id_ld,
    input  logic                      flush,
    input  logic                      hold,
    output logic                      stall,
    output logic [NSRC-1:0][SW-1:0]   fwd_sel
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               fwd_count
`endif
);

    typedef struct packed {
        logic       valid;
        logic       we;
        logic       ld;
        logic [4:0] rd;
    } entry_t;

    entry_t                    s_q [1:DEPTH];
    entry_t                    s1_d;
    logic [NSRC-1:0][SW-1:0]   fwd_q, fwd_d, fwd_nxt;
    logic [NSRC-1:0]           hit, hit_ld, haz;
    int                        hit_k [NSRC];
    logic                      accept;

    // Youngest matching writer per source: scan oldest-to-youngest so the smallest stage wins.
    always_comb begin
        hit     = '0;
        hit_ld  = '0;
        haz     = '0;
        fwd_nxt = '0;
        for (int j = 0; j < NSRC; j++) begin
            hit_k[j] = 0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (id_rs_used[j] && (id_rs[j] != 5'd0) && s_q[k].valid &&
                    s_q[k].we && (s_q[k].rd == id_rs[j])) begin
                    hit[j]    = 1'b1;
                    hit_ld[j] = s_q[k].ld;
                    hit_k[j]  = k;
                end
            end
            haz[j] = hit[j] && hit_ld[j] && ((hit_k[j] + 1) < LOAD_AVAIL);
            if (hit[j] && !haz[j] && ((hit_k[j] + 1) <= DEPTH))
                fwd_nxt[j] = SW'(hit_k[j] + 1);
        end
    end

    always_comb begin
        stall  = id_valid && !flush && (|haz);
        accept = id_valid && !stall && !flush && !hold;
        s1_d   = '0;
        fwd_d  = '0;
        if (accept) begin
            s1_d  = '{valid: 1'b1, we: id_we, ld: id_ld, rd: id_rd};
            fwd_d = fwd_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= DEPTH; k++) s_q[k] <= '0;
            fwd_q <= '0;
        end else if (!hold) begin
            for (int k = DEPTH; k >= 2; k--) s_q[k] <= s_q[k-1];
            s_q[1] <= s1_d;
            fwd_q  <= fwd_d;
        end
    end

    assign fwd_sel = fwd_q;

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles_q, fwd_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            fwd_count_q    <= '0;
        end else begin
            if (stall && !hold) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (accept && (|fwd_d)) fwd_count_q <= fwd_count_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign fwd_count    = fwd_count_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (NSRC=2, DEPTH=3, LOAD_AVAIL=3) with a queue of expected forwarding selects.
module tb_hazard_scoreboard;

    localparam int NSRC = 2;
    localparam int DEPTH = 3;
    localparam int SW = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    id_valid;
    logic [NSRC-1:0][4:0]    id_rs;
    logic [NSRC-1:0]         id_rs_used;
    logic [4:0]              id_rd;
    logic                    id_we, id_ld, flush, hold;
    logic                    stall;
    logic [NSRC-1:0][SW-1:0] fwd_sel;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0]             stall_cycles, fwd_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int exp_q0[$];
    int exp_q1[$];

    hazard_scoreboard #(.NSRC(NSRC), .DEPTH(DEPTH), .LOAD_AVAIL(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .id_rd      (id_rd),
        .id_we      (id_we),
        .id_ld      (id_ld),
        .flush      (flush),
        .hold       (hold),
        .stall      (stall),
        .fwd_sel    (fwd_sel)
`ifdef HAZARD_SCOREBOARD_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .fwd_count    (fwd_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one decode cycle, check stall before the edge, queue the expected selects, compare after the edge.
    task automatic cyc(input string tag, input logic v, input int rs0, input int rs1,
                       input logic [1:0] used, input int rd, input logic we, input logic ld,
                       input logic fl, input logic hd, input logic exp_stall,
                       input int ef0, input int ef1);
        int e0, e1;
        id_valid   = v;
        id_rs[0]   = 5'(rs0);
        id_rs[1]   = 5'(rs1);
        id_rs_used = used;
        id_rd      = 5'(rd);
        id_we      = we;
        id_ld      = ld;
        flush      = fl;
        hold       = hd;
        #1;
        check({tag, "_stall"}, int'(stall), int'(exp_stall));
        exp_q0.push_back(ef0);
        exp_q1.push_back(ef1);
        @(posedge clk);
        #1;
        e0 = exp_q0.pop_front();
        e1 = exp_q1.pop_front();
        check({tag, "_fwd0"}, int'(fwd_sel[0]), e0);
        check({tag, "_fwd1"}, int'(fwd_sel[1]), e1);
    endtask

    initial begin
        reset = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rs_used = '0; id_rd = '0;
        id_we = 1'b0; id_ld = 1'b0; flush = 1'b0; hold = 1'b0;
        #12;
        check("rst_stall", int'(stall), 0);
        check("rst_fwd", int'(fwd_sel), 0);
        reset = 1'b1;

        // producer/consumer back to back forwards from MEM
        cyc("add5",  1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 0, 0, 0);
        cyc("use5",  1, 5, 0, 2'b01, 6, 1, 0, 0, 0, 0, 2, 0);
        cyc("nop1",  0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("nop2",  0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("nop3",  0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        // load-use: one stall cycle then forward from WB
        cyc("lw7",   1, 0, 0, 2'b00, 7, 1, 1, 0, 0, 0, 0, 0);
        cyc("lu_st", 1, 0, 7, 2'b10, 8, 1, 0, 0, 0, 1, 0, 0);
        cyc("lu_go", 1, 0, 7, 2'b10, 8, 1, 0, 0, 0, 0, 0, 3);
        // x0 never forwards
        cyc("p_x0",  1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("use_x0",1, 0, 0, 2'b01, 9, 1, 0, 0, 0, 0, 0, 0);
        // youngest of two writers wins
        cyc("a5a",   1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 0, 0, 0);
        cyc("a5b",   1, 9, 0, 2'b01, 5, 1, 0, 0, 0, 0, 3, 0);
        cyc("young", 1, 5, 5, 2'b11, 10, 1, 0, 0, 0, 0, 2, 2);
        // writer beyond DEPTH covered by regfile
        cyc("a11",   1, 0, 0, 2'b00, 11, 1, 0, 0, 0, 0, 0, 0);
        cyc("f12",   1, 0, 0, 2'b00, 12, 1, 0, 0, 0, 0, 0, 0);
        cyc("f13",   1, 0, 0, 2'b00, 13, 1, 0, 0, 0, 0, 0, 0);
        cyc("far",   1, 11, 0, 2'b01, 14, 1, 0, 0, 0, 0, 0, 0);
        // we=0 and unused source do not forward
        cyc("w15",   1, 0, 0, 2'b00, 15, 0, 0, 0, 0, 0, 0, 0);
        cyc("use_we0",1, 15, 0, 2'b01, 16, 1, 0, 0, 0, 0, 0, 0);
        cyc("unused",1, 16, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        // hold freezes state during a load-use stall, then flush kills the consumer
        cyc("lw20",  1, 16, 0, 2'b01, 20, 1, 1, 0, 0, 0, 3, 0);
        cyc("hold1", 1, 20, 0, 2'b01, 21, 1, 0, 0, 1, 1, 3, 0);
        cyc("hold2", 1, 20, 0, 2'b01, 21, 1, 0, 0, 1, 1, 3, 0);
        cyc("hold3", 1, 20, 0, 2'b01, 21, 1, 0, 0, 1, 1, 3, 0);
        cyc("flush", 1, 20, 0, 2'b01, 21, 1, 0, 1, 0, 0, 0, 0);
        cyc("postfl",1, 20, 0, 2'b01, 21, 1, 0, 0, 0, 0, 3, 0);
        cyc("lw22",  1, 21, 0, 2'b01, 22, 1, 1, 0, 0, 0, 2, 0);

        // asynchronous reset in the middle of a stall
        id_valid = 1'b1; id_rs[0] = 5'd22; id_rs[1] = 5'd0; id_rs_used = 2'b01;
        id_rd = 5'd23; id_we = 1'b1; id_ld = 1'b0; flush = 1'b0; hold = 1'b0;
        #1;
        check("pre_rst_stall", int'(stall), 1);
`ifdef HAZARD_SCOREBOARD_PERF_EN
        check("pre_rst_stallcyc", int'(stall_cycles), 1);
        check("pre_rst_fwdcnt", int'(fwd_count), 7);
`endif
        reset = 1'b0;
        #1;
        check("mid_rst_stall", int'(stall), 0);
        check("mid_rst_fwd", int'(fwd_sel), 0);
`ifdef HAZARD_SCOREBOARD_PERF_EN
        check("mid_rst_stallcyc", int'(stall_cycles), 0);
        check("mid_rst_fwdcnt", int'(fwd_count), 0);
`endif
        #1;
        reset = 1'b1;
        cyc("after_rst", 1, 22, 0, 2'b01, 23, 1, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NSRC, default 2: source operands checked per decoded instruction (1..3).
REQ-002 Parameter DEPTH, default 3: tracked stages after decode; stage 1=EX, 2=MEM, 3=WB (2..6).
REQ-003 Parameter LOAD_AVAIL, default 3: first stage whose result carries load data (2..DEPTH).
REQ-004 Parameter SW = $clog2(DEPTH+1): width of each forwarding select.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-low; state clears while 0.
REQ-007 id_valid  in  1  decode stage holds an instruction.
REQ-008 id_rs  in  NSRC x 5  source register numbers of decoded instruction.
REQ-009 id_rs_used  in  NSRC  per-source "operand read" flag.
REQ-010 id_rd, id_we, id_ld  in  5,1,1  destination, register-write, is-load of decoded instruction.
REQ-011 flush  in  1  branch redirect; kills decoded instruction.
REQ-012 hold  in  1  memory busy; freezes whole pipeline.
REQ-013 stall  out  1  combinational; freeze fetch/decode, bubble EX.
REQ-014 fwd_sel  out  NSRC x SW  registered; operand source for instruction now in EX: 0=regfile, k=stage k result.

Function
REQ-015 Internal shadow pipe s[1..DEPTH], entry = {valid, we, ld, rd[4:0]}.
REQ-016 Match for source j at stage k: id_rs_used[j] & id_rs[j]!=0 & s[k].valid & s[k].we & s[k].rd==id_rs[j].
REQ-017 Youngest match (smallest k) wins; no match -> regfile.
REQ-018 Load-use hazard: youngest match has s[k].ld and k+1 < LOAD_AVAIL.
REQ-019 stall = id_valid & ~flush & (load-use hazard on any source); independent of hold.
REQ-020 accept = id_valid & ~stall & ~flush & ~hold.
REQ-021 hold=1: s[], fwd_sel, counters unchanged; overrides flush and stall.
REQ-022 hold=0: s[k+1] <= s[k] for k<DEPTH; s[DEPTH] retires.
REQ-023 hold=0: s[1] <= {1,id_we,id_ld,id_rd} if accept, else bubble (valid=0).
REQ-024 hold=0: fwd_sel[j] <= k+1 for youngest match k with k+1<=DEPTH and not hazard, else 0.
REQ-025 Match with k+1 > DEPTH yields 0 (regfile write-through covers it).
REQ-026 Bubble in s[1] yields fwd_sel all 0.
REQ-027 flush and stall together: flush wins, stall=0, bubble inserted.
REQ-028 id_we=0 or id_rd=0 entries never forward.

Reset
REQ-029 reset=0: all s[k].valid=0, fwd_sel=0, counters=0, immediately, regardless of clk.
REQ-030 stall=0 while reset=0; first capture on first rising edge after release.

Configuration
REQ-031 Macro HAZARD_SCOREBOARD_PERF_EN defined: adds outputs stall_cycles[31:0] and fwd_count[31:0].
REQ-032 stall_cycles +1 per edge with stall=1 & hold=0; fwd_count +1 per accepted instruction with any nonzero next fwd_sel; both wrap at 2^32.
REQ-033 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-034 add x5 accepted, next cycle consumer rs1=x5 -> stall=0; when consumer in EX fwd_sel[0]=2.
REQ-035 lw x7 then consumer rs2=x7 -> stall=1 exactly one cycle, then fwd_sel[1]=3.
REQ-036 Producer rd=x0, consumer rs1=x0 -> stall=0, fwd_sel[0]=0.
REQ-037 add x5, add x5, consumer x5 -> fwd_sel[0]=2 (youngest); with gap of 3 instrs -> 0.
REQ-038 Load-use stall with hold=1 for 3 cycles -> s[], fwd_sel frozen, stall stays 1; then flush=1 -> stall=0, bubble.
REQ-039 reset=0 mid-stall between edges -> stall and fwd_sel 0 at once; PERF_EN counters read 0.
